ray_dispatcher: RTL and testbench
=================================

Name: ray_dispatcher

Overview:
- Sits between the ray generator and a bank of NUM_UNITS ray units.
- Buffers generated rays, each a direction vector plus a pixel address, in a small FIFO.
- Issues each buffered ray to the next ready unit in round-robin order, so several units can trace in parallel.
- Reports an aggregate busy to the config block so frame completion is signalled only after the last ray has been dispatched and every unit has gone idle.

Parameters:
- POSITION_WIDTH, 16, width of one vector component.
- ADDRESS_WIDTH, 32, pixel address width.
- NUM_UNITS, 4, number of downstream ray units; 1..16.
- DEPTH, 4, FIFO entries; power of two, >=2.

Ports:
- clock  in  1  system clock.
- reset  in  1  asynchronous, active-low reset.
- flush  in  1  synchronous; discards buffered rays.
- rayV  in  3*POSITION_WIDTH  {z,y,x} ray direction from the generator.
- rayAddress  in  ADDRESS_WIDTH  pixel address of the ray.
- rayStart  in  1  generator presents a valid ray.
- rayReady  out  1  dispatcher can accept a ray.
- busy  out  1  rays buffered, in flight, or any unit busy.
- unitV  out  3*POSITION_WIDTH  ray direction, shared by all units.
- unitAddress  out  ADDRESS_WIDTH  pixel address, shared by all units.
- unitStart  out  NUM_UNITS  one-hot, one-cycle issue pulse.
- unitReady  in  NUM_UNITS  per-unit ready.
- unitBusy  in  NUM_UNITS  per-unit busy.
- rayCount  out  32  rays issued since reset or flush.

Behaviour:
- Reset (reset=0, asynchronous):
  - FIFO empty, count=0, read/write pointers 0, round-robin pointer rr=0.
  - unitStart=0, unitV=0, unitAddress=0, rayCount=0, lastIssued mask=0.
  - rayReady and busy are then driven per the rules below.
- Input handshake:
  - rayReady = (count < DEPTH) && !flush, combinational.
  - A ray is accepted on a rising edge where rayStart && rayReady; it is written at the write pointer.
  - No push when full, even if a pop occurs in the same cycle.
- Dispatch decision, combinational in cycle c:
  - eligible = unitReady & ~lastIssued.
  - If count>0 and eligible is non-zero, the winner is the first set bit of eligible scanning rr, rr+1, ..., wrapping modulo NUM_UNITS.
- Issue, registered at the edge ending cycle c:
  - unitStart = onehot(winner) for exactly one cycle (c+1).
  - unitV/unitAddress take the FIFO head data and hold until the next issue.
  - Head is popped; rr <= winner+1 mod NUM_UNITS; rayCount <= rayCount+1, wrapping at 2^32.
  - lastIssued <= onehot(winner), or 0 if no issue. This stops a unit whose unitReady has not yet dropped from receiving two rays back to back.
- At most one issue per cycle.
- Latency: a ray accepted at edge t into an empty FIFO issues with unitStart high in cycle t+1 at the earliest. Best-case sustained throughput is 1 ray/cycle with NUM_UNITS>=2.
- Push and pop in the same cycle: count unchanged, both pointers advance. Pointers wrap modulo DEPTH.
- busy = (count!=0) || (|unitStart) || (|unitBusy), combinational.
- flush=1 at an edge:
  - Empties the FIFO (count=0, pointers=0), clears unitStart, lastIssued and rayCount.
  - Any rayStart in that cycle is dropped, since rayReady=0.
  - rr is held.
  - A unit issued in the cycle before flush keeps its ray; discarding it is the unit's own flush responsibility.
- No unit ready: the head ray waits indefinitely, and FIFO contents and order are preserved (FIFO order in equals issue order out).
- NUM_UNITS=1: lastIssued forces a gap, giving a maximum rate of 1 ray per 2 cycles.

Test Plan:
- Reset while count=3 and unitStart active -> immediately unitStart=0, rayCount=0, busy=|unitBusy; after release, rayReady=1.
- Four rays pushed back-to-back, addresses 0x100..0x103, all units ready, NUM_UNITS=4 -> unitStart = 0001, 0010, 0100, 1000 in consecutive cycles, first in the cycle after the first accept; unitAddress = 0x100..0x103 in order; rayCount=4.
- All unitReady=0, push 5 rays with DEPTH=4 -> rayReady drops after the 4th accept and the 5th stays stalled. Raise unitReady[2] only -> issues go only to unit 2, at most every other cycle, and rayReady returns the cycle after the first pop.
- unitReady=1010 with rr=0 -> first issue goes to unit 1, next to unit 3, then wraps to unit 1.
- Flush with 3 buffered rays and a simultaneous rayStart -> count=0, rayCount=0, no unitStart next cycle, busy falls once unitBusy=0, new ray accepted the following cycle.
- Frame completion: stream 16 rays, units hold busy 5 cycles each -> busy stays 1 until the last unitBusy deasserts, then 0 in the same cycle.

Source files
------------

// File: rtl/ray_dispatcher_if.sv
// ray_dispatcher_if: bundles the generator-side and unit-side signals of the
// ray dispatcher.
//   slave  : the dispatcher. It takes in the generator ray and the unit
//            ready/busy vectors. It drives rayReady, busy, the shared unit
//            ray, the unitStart pulses and rayCount.
//   master : the environment, meaning the ray generator plus the bank of ray
//            units.
interface ray_dispatcher_if #(
  parameter int POSITION_WIDTH = 16,
  parameter int ADDRESS_WIDTH  = 32,
  parameter int NUM_UNITS      = 4
);
  logic [3*POSITION_WIDTH-1:0] rayV;
  logic [ADDRESS_WIDTH-1:0]    rayAddress;
  logic                        rayStart;
  logic                        rayReady;
  logic                        busy;
  logic [3*POSITION_WIDTH-1:0] unitV;
  logic [ADDRESS_WIDTH-1:0]    unitAddress;
  logic [NUM_UNITS-1:0]        unitStart;
  logic [NUM_UNITS-1:0]        unitReady;
  logic [NUM_UNITS-1:0]        unitBusy;
  logic [31:0]                 rayCount;

  modport slave (
    input  rayV, rayAddress, rayStart, unitReady, unitBusy,
    output rayReady, busy, unitV, unitAddress, unitStart, rayCount
  );

  modport master (
    output rayV, rayAddress, rayStart, unitReady, unitBusy,
    input  rayReady, busy, unitV, unitAddress, unitStart, rayCount
  );
endinterface

// File: rtl/ray_dispatcher.sv
// ray_dispatcher: buffers generated rays in a small FIFO. It issues each ray
// to the next ready ray unit in round-robin order, and reports an aggregate
// busy so that frame completion can be detected.
// Ports:
//   clock : system clock.
//   reset : asynchronous, active-low reset.
//   flush : synchronous. Discards buffered rays and clears the issue count.
//   bus   : ray_dispatcher_if.slave. Carries the generator handshake
//           (rayV, rayAddress, rayStart, rayReady), the unit side (unitV,
//           unitAddress, unitStart, unitReady, unitBusy), busy and rayCount.
module ray_dispatcher #(
  parameter int POSITION_WIDTH = 16,
  parameter int ADDRESS_WIDTH  = 32,
  parameter int NUM_UNITS      = 4,
  parameter int DEPTH          = 4
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             flush,
  ray_dispatcher_if.slave  bus
);

  localparam int VEC_W = 3 * POSITION_WIDTH;
  localparam int PTR_W = $clog2(DEPTH);
  localparam int RR_W  = (NUM_UNITS > 1) ? $clog2(NUM_UNITS) : 1;
  localparam logic [PTR_W:0] DEPTH_C = (PTR_W + 1)'(DEPTH);
  localparam logic [RR_W:0]  UNITS_C = (RR_W + 1)'(NUM_UNITS);

  logic [VEC_W-1:0]         r_fifo_v    [DEPTH];
  logic [ADDRESS_WIDTH-1:0] r_fifo_addr [DEPTH];
  logic [PTR_W-1:0]         r_wr_ptr;
  logic [PTR_W-1:0]         r_rd_ptr;
  logic [PTR_W:0]           r_count;
  logic [RR_W-1:0]          r_rr;
  logic [NUM_UNITS-1:0]     r_last_issued;
  logic [NUM_UNITS-1:0]     r_unit_start;
  logic [VEC_W-1:0]         r_unit_v;
  logic [ADDRESS_WIDTH-1:0] r_unit_addr;
  logic [31:0]              r_ray_count;

  logic                     w_ray_ready;
  logic                     w_push;
  logic                     w_issue;
  logic [NUM_UNITS-1:0]     w_eligible;
  logic                     w_found;
  logic [RR_W-1:0]          w_winner;
  logic [RR_W:0]            w_cand;
  logic [RR_W:0]            w_rr_next;
  logic [NUM_UNITS-1:0]     w_winner_onehot;

  assign w_ray_ready = (r_count < DEPTH_C) && !flush;
  assign w_push      = bus.rayStart && w_ray_ready;

  // A unit issued last cycle may still show ready. It is masked out for one
  // cycle so that it cannot receive two rays back to back.
  assign w_eligible = bus.unitReady & ~r_last_issued;

  // Scan rr, rr+1, ... (wrapping) and take the first eligible unit.
  always_comb begin
    w_found  = 1'b0;
    w_winner = '0;
    w_cand   = '0;
    for (int i = 0; i < NUM_UNITS; i++) begin
      w_cand = {1'b0, r_rr} + (RR_W + 1)'(i);
      if (w_cand >= UNITS_C) begin
        w_cand = w_cand - UNITS_C;
      end
      if (!w_found && w_eligible[w_cand[RR_W-1:0]]) begin
        w_found  = 1'b1;
        w_winner = w_cand[RR_W-1:0];
      end
    end
  end

  assign w_issue         = (r_count != '0) && w_found;
  assign w_winner_onehot = NUM_UNITS'(1) << w_winner;

  always_comb begin
    w_rr_next = {1'b0, w_winner} + 1'b1;
    if (w_rr_next >= UNITS_C) begin
      w_rr_next = '0;
    end
  end

  // FIFO storage holds only data. Its validity is tracked by r_count, so the
  // storage needs no reset.
  always_ff @(posedge clock) begin
    if (w_push) begin
      r_fifo_v[r_wr_ptr]    <= bus.rayV;
      r_fifo_addr[r_wr_ptr] <= bus.rayAddress;
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_wr_ptr      <= '0;
      r_rd_ptr      <= '0;
      r_count       <= '0;
      r_rr          <= '0;
      r_last_issued <= '0;
      r_unit_start  <= '0;
      r_unit_v      <= '0;
      r_unit_addr   <= '0;
      r_ray_count   <= '0;
    end else if (flush) begin
      // rr and the last issued ray data are deliberately kept.
      r_wr_ptr      <= '0;
      r_rd_ptr      <= '0;
      r_count       <= '0;
      r_last_issued <= '0;
      r_unit_start  <= '0;
      r_ray_count   <= '0;
    end else begin
      if (w_push) begin
        r_wr_ptr <= r_wr_ptr + 1'b1;
      end
      if (w_issue) begin
        r_rd_ptr      <= r_rd_ptr + 1'b1;
        r_rr          <= w_rr_next[RR_W-1:0];
        r_unit_v      <= r_fifo_v[r_rd_ptr];
        r_unit_addr   <= r_fifo_addr[r_rd_ptr];
        r_ray_count   <= r_ray_count + 32'd1;
        r_unit_start  <= w_winner_onehot;
        r_last_issued <= w_winner_onehot;
      end else begin
        r_unit_start  <= '0;
        r_last_issued <= '0;
      end
      case ({w_push, w_issue})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

  assign bus.rayReady    = w_ray_ready;
  assign bus.busy        = (r_count != '0) || (|r_unit_start) || (|bus.unitBusy);
  assign bus.unitV       = r_unit_v;
  assign bus.unitAddress = r_unit_addr;
  assign bus.unitStart   = r_unit_start;
  assign bus.rayCount    = r_ray_count;

endmodule

// File: tb/tb_ray_dispatcher.sv
// tb_ray_dispatcher: directed test of ray_dispatcher with NUM_UNITS=4 and
// DEPTH=4. Unit ready/busy come either from directly driven values or from a
// small unit model that stays busy for 5 cycles after each issue.
module tb_ray_dispatcher;

  localparam int PW = 16;
  localparam int AW = 32;
  localparam int NU = 4;
  localparam int DP = 4;

  logic clock;
  logic reset;
  logic flush;

  ray_dispatcher_if #(.POSITION_WIDTH(PW), .ADDRESS_WIDTH(AW), .NUM_UNITS(NU)) bus ();

  ray_dispatcher #(
    .POSITION_WIDTH(PW), .ADDRESS_WIDTH(AW), .NUM_UNITS(NU), .DEPTH(DP)
  ) dut (
    .clock (clock),
    .reset (reset),
    .flush (flush),
    .bus   (bus)
  );

  int errors = 0;
  int checks = 0;

  logic          model_en;
  logic [NU-1:0] d_ready;
  logic [NU-1:0] d_busy;
  logic [2:0]    m_cnt [NU];
  logic [NU-1:0] m_ready;
  logic [NU-1:0] m_busy;
  int            m_issued;

  assign bus.unitReady = model_en ? m_ready : d_ready;
  assign bus.unitBusy  = model_en ? m_busy  : d_busy;

  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  // Unit model: on seeing unitStart at an edge, the unit goes busy and
  // not-ready for 5 cycles.
  always @(posedge clock) begin
    if (!model_en) begin
      for (int i = 0; i < NU; i++) m_cnt[i] <= 3'd0;
      m_issued <= 0;
    end else begin
      for (int i = 0; i < NU; i++) begin
        if (bus.unitStart[i]) m_cnt[i] <= 3'd5;
        else if (m_cnt[i] != 3'd0) m_cnt[i] <= m_cnt[i] - 3'd1;
      end
      m_issued <= m_issued + $countones(bus.unitStart);
    end
  end

  always_comb begin
    m_ready = '0;
    m_busy  = '0;
    for (int i = 0; i < NU; i++) begin
      m_ready[i] = (m_cnt[i] == 3'd0);
      m_busy[i]  = (m_cnt[i] != 3'd0);
    end
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  logic [NU-1:0] exp_us [8];
  logic          acc;
  logic          exp_busy;
  logic          done;
  int            pushed;

  initial begin
    model_en       = 1'b0;
    d_ready        = '0;
    d_busy         = '0;
    reset          = 1'b0;
    flush          = 1'b0;
    bus.rayV       = '0;
    bus.rayAddress = '0;
    bus.rayStart   = 1'b0;

    // Reset values.
    #1;
    check("rst_unitStart", bus.unitStart, 0);
    check("rst_rayCount", bus.rayCount, 0);
    check("rst_unitAddress", bus.unitAddress, 0);
    check("rst_busy", bus.busy, 0);
    check("rst_rayReady", bus.rayReady, 1);
    step();
    reset = 1'b1;
    step();
    check("rel_rayReady", bus.rayReady, 1);

    // Four back-to-back rays, all units ready: the issue order is 0,1,2,3.
    d_ready = 4'b1111;
    exp_us[1] = 4'b0000; exp_us[2] = 4'b0001; exp_us[3] = 4'b0010;
    exp_us[4] = 4'b0100; exp_us[5] = 4'b1000; exp_us[6] = 4'b0000;
    for (int j = 1; j <= 6; j++) begin
      bus.rayStart   = (j <= 4);
      bus.rayAddress = 32'h100 + 32'(j - 1);
      bus.rayV       = 48'h0000_CAFE_0000 + 48'(j - 1);
      step();
      check("rr4_unitStart", bus.unitStart, exp_us[j]);
      if (j >= 2 && j <= 5) check("rr4_unitAddress", bus.unitAddress, 32'h100 + 32'(j - 2));
      if (j == 2) check("rr4_unitV_first", bus.unitV, 48'h0000_CAFE_0000);
      if (j == 5) check("rr4_unitV_last", bus.unitV, 48'h0000_CAFE_0003);
    end
    check("rr4_rayCount", bus.rayCount, 4);
    check("rr4_busy_idle", bus.busy, 0);

    // unitReady=1010 with rr=0: the issue order is 1, 3, then wrap back to 1.
    d_ready = 4'b1010;
    exp_us[1] = 4'b0000; exp_us[2] = 4'b0010; exp_us[3] = 4'b1000;
    exp_us[4] = 4'b0010; exp_us[5] = 4'b0000;
    for (int j = 1; j <= 5; j++) begin
      bus.rayStart   = (j <= 3);
      bus.rayAddress = 32'h300 + 32'(j - 1);
      step();
      check("rr2_unitStart", bus.unitStart, exp_us[j]);
      if (j >= 2 && j <= 4) check("rr2_unitAddress", bus.unitAddress, 32'h300 + 32'(j - 2));
    end
    check("rr2_rayCount", bus.rayCount, 7);

    // No unit ready: the FIFO fills and the fifth ray stalls.
    d_ready = 4'b0000;
    for (int k = 0; k < 4; k++) begin
      bus.rayStart   = 1'b1;
      bus.rayAddress = 32'h200 + 32'(k);
      #1;
      check("full_rayReady_open", bus.rayReady, 1);
      step();
    end
    bus.rayAddress = 32'h204;
    #1;
    check("full_rayReady_closed", bus.rayReady, 0);
    step();
    step();
    check("full_stall_unitStart", bus.unitStart, 0);
    check("full_stall_rayReady", bus.rayReady, 0);
    check("full_stall_busy", bus.busy, 1);
    // Only unit 2 ready: it receives a ray at most every other cycle.
    d_ready = 4'b0100;
    for (int j = 0; j < 10; j++) begin
      step();
      check("u2_unitStart", bus.unitStart, (j % 2 == 0) ? 4'b0100 : 4'b0000);
      if (j % 2 == 0) check("u2_unitAddress", bus.unitAddress, 32'h200 + 32'(j / 2));
      if (j == 0) check("u2_rayReady_back", bus.rayReady, 1);
      if (j == 1) bus.rayStart = 1'b0;
    end
    check("u2_rayCount", bus.rayCount, 12);
    check("u2_busy_idle", bus.busy, 0);

    // Flush with 3 buffered rays and a simultaneous rayStart.
    d_ready = 4'b0000;
    for (int k = 0; k < 3; k++) begin
      bus.rayStart   = 1'b1;
      bus.rayAddress = 32'h500 + 32'(k);
      step();
    end
    flush          = 1'b1;
    bus.rayAddress = 32'h5FF;
    d_busy         = 4'b0001;
    #1;
    check("fl_rayReady_low", bus.rayReady, 0);
    step();
    flush        = 1'b0;
    bus.rayStart = 1'b0;
    #1;
    check("fl_unitStart", bus.unitStart, 0);
    check("fl_rayCount", bus.rayCount, 0);
    check("fl_busy_unit", bus.busy, 1);
    check("fl_rayReady_back", bus.rayReady, 1);
    d_busy = 4'b0000;
    #1;
    check("fl_busy_low", bus.busy, 0);
    d_ready        = 4'b1111;
    bus.rayStart   = 1'b1;
    bus.rayAddress = 32'h600;
    step();
    bus.rayStart = 1'b0;
    step();
    check("fl_new_unitStart", bus.unitStart, 4'b1000);
    check("fl_new_unitAddress", bus.unitAddress, 32'h600);
    check("fl_new_rayCount", bus.rayCount, 1);

    // Reset while count=3 and unitStart is active.
    d_ready = 4'b0000;
    for (int k = 0; k < 4; k++) begin
      bus.rayStart   = 1'b1;
      bus.rayAddress = 32'h800 + 32'(k);
      step();
    end
    bus.rayStart = 1'b0;
    d_ready      = 4'b0001;
    step();
    check("ar_pre_unitStart", bus.unitStart, 4'b0001);
    check("ar_pre_unitAddress", bus.unitAddress, 32'h800);
    reset  = 1'b0;
    d_busy = 4'b0010;
    #1;
    check("ar_unitStart", bus.unitStart, 0);
    check("ar_rayCount", bus.rayCount, 0);
    check("ar_busy_unit", bus.busy, 1);
    check("ar_unitAddress", bus.unitAddress, 0);
    d_busy = 4'b0000;
    #1;
    check("ar_busy_low", bus.busy, 0);
    d_ready = 4'b0000;
    reset   = 1'b1;
    step();
    check("ar_rel_rayReady", bus.rayReady, 1);
    check("ar_rel_unitStart", bus.unitStart, 0);

    // Frame completion: 16 rays, each unit stays busy 5 cycles per ray.
    model_en = 1'b1;
    step();
    pushed = 0;
    done   = 1'b0;
    for (int cyc = 0; cyc < 300 && !done; cyc++) begin
      bus.rayStart   = (pushed < 16);
      bus.rayAddress = 32'h700 + 32'(pushed);
      #1;
      acc = bus.rayStart && bus.rayReady;
      step();
      if (acc) pushed++;
      exp_busy = (m_issued < 16) || (|m_busy);
      check("frame_busy", bus.busy, exp_busy);
      if (m_issued == 16 && m_busy == '0) done = 1'b1;
    end
    bus.rayStart = 1'b0;
    check("frame_done", done, 1);
    check("frame_pushed", pushed, 16);
    check("frame_rayCount", bus.rayCount, 16);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
